// File: rtl/cypherdb_pkg.sv
// Shared types and constants for the CypherDB secure-window sequencer.
// Holds the sequencer state encoding, the wait-counter width and error causes.
// Error cause codes are reserved for a future cause register.
package cypherdb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      KEY    = 2'd1,
      ACTIVE = 2'd2,
      FLUSH  = 2'd3
   } seq_state_t;

   localparam int CYPHERDB_WAIT_W = 16;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_TIMEOUT   = 2'd1,
      ERR_NEST      = 2'd2,
      ERR_IDLE_EXIT = 2'd3
   } err_cause_t;

endpackage

// File: rtl/cypherdb_wait_timer.sv
// Clearable acknowledge-wait counter shared by the KEY and FLUSH handshakes.
// Counts cycles while enabled; tc is high when the count equals TIMEOUT-1.
// The count holds at all-ones rather than wrapping.
module cypherdb_wait_timer
   import cypherdb_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CYPHERDB_WAIT_W-1:0] TC_VAL = CYPHERDB_WAIT_W'(TIMEOUT - 1);

   logic [CYPHERDB_WAIT_W-1:0] cnt;

   // Restart on handshake entry, otherwise count cycles spent waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/cypherdb_secure_seq.sv
// Secure-window entry/exit sequencer: key load, window open, flush, window close.
// All outputs registered; request-to-response latency is one cycle.
// Stalls the pipeline while a key-load or flush handshake is outstanding.
module cypherdb_secure_seq
   import cypherdb_pkg::*;
#(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             enter_req,
   input  logic             exit_req,
   input  logic             exc_req,
   output logic             key_req,
   input  logic             key_ack,
   output logic             flush_req,
   input  logic             flush_ack,
   output logic             start_pulse,
   output logic             end_pulse,
   output logic             secure_active,
   output logic             stall,
   output logic             err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] sec_cycles
);

   seq_state_t       state, state_nxt;
   logic             pend_exit, pend_nxt;
   logic             err_set;
   logic             start_nxt, end_nxt;
   logic [CNT_W-1:0] sec_nxt;
   logic             enter, leave;
   logic             wait_clr, wait_en, wait_tc;

   // Decode instructions only count when the pipeline is advancing.
   assign enter = enter_req & ce;
   assign leave = exit_req & ce;

   // One timer serves both handshakes; it restarts whenever KEY or FLUSH is entered.
   assign wait_en  = (state == KEY) || (state == FLUSH);
   assign wait_clr = (state_nxt != state) && ((state_nxt == KEY) || (state_nxt == FLUSH));

   cypherdb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk (clk),
      .rst (rst),
      .clr (wait_clr),
      .en  (wait_en),
      .tc  (wait_tc)
   );

   // Next-state, pulse and counter decisions for the handshake sequence.
   always_comb begin
      state_nxt = state;
      pend_nxt  = pend_exit;
      err_set   = 1'b0;
      start_nxt = 1'b0;
      end_nxt   = 1'b0;
      sec_nxt   = sec_cycles;
      case (state)
         IDLE: begin
            if (enter) begin
               state_nxt = KEY;
               pend_nxt  = 1'b0;
               sec_nxt   = '0;
            end else if (leave) begin
               err_set = 1'b1;
            end
         end
         KEY: begin
            // An exit during key load is remembered; the handshake still completes.
            if (exc_req || leave) begin
               pend_nxt = 1'b1;
            end
            if (key_ack) begin
               state_nxt = ACTIVE;
               start_nxt = 1'b1;
            end else if (wait_tc) begin
               state_nxt = IDLE;
               err_set   = 1'b1;
            end
         end
         ACTIVE: begin
            if (sec_cycles != '1) begin
               sec_nxt = sec_cycles + 1'b1;
            end
            if (enter) begin
               err_set = 1'b1;
            end
            if (leave || exc_req || pend_exit) begin
               state_nxt = FLUSH;
               pend_nxt  = 1'b0;
            end
         end
         FLUSH: begin
            // The window always closes, with or without the flush acknowledge.
            if (flush_ack) begin
               state_nxt = IDLE;
               end_nxt   = 1'b1;
            end else if (wait_tc) begin
               state_nxt = IDLE;
               end_nxt   = 1'b1;
               err_set   = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register and pending-exit flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pend_exit <= 1'b0;
      end else begin
         state     <= state_nxt;
         pend_exit <= pend_nxt;
      end
   end

   // Registered outputs, derived from the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_req       <= 1'b0;
         flush_req     <= 1'b0;
         secure_active <= 1'b0;
         stall         <= 1'b0;
         start_pulse   <= 1'b0;
         end_pulse     <= 1'b0;
         sec_cycles    <= '0;
      end else begin
         key_req       <= (state_nxt == KEY);
         flush_req     <= (state_nxt == FLUSH);
         secure_active <= (state_nxt == ACTIVE);
         stall         <= (state_nxt == KEY) || (state_nxt == FLUSH);
         start_pulse   <= start_nxt;
         end_pulse     <= end_nxt;
         sec_cycles    <= sec_nxt;
      end
   end

   // Sticky error: a new error event takes priority over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (err_set) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cypherdb_secure_seq.sv
// Directed bench for the secure-window sequencer with a cycle-level reference model.
// Every cycle after reset the DUT outputs are compared against the model.
// Literal expectations pin pulse timing, durations and counter values per scenario.
module tb_cypherdb_secure_seq;

   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 4;
   localparam int SEC_MAX = (1 << CNT_W) - 1;

   localparam int M_IDLE   = 0;
   localparam int M_KEY    = 1;
   localparam int M_ACTIVE = 2;
   localparam int M_FLUSH  = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ce = 1'b1;
   logic             enter_req = 1'b0, exit_req = 1'b0, exc_req = 1'b0;
   logic             key_ack = 1'b0, flush_ack = 1'b0, err_clr = 1'b0;
   logic             key_req, flush_req, start_pulse, end_pulse, secure_active, stall, err;
   logic [CNT_W-1:0] sec_cycles;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit cmp_en = 1'b0;

   // model state
   int m_ph = M_IDLE;
   int m_held = 0;
   int m_sec = 0;
   bit m_pend = 1'b0;
   bit m_err = 1'b0;
   bit m_start = 1'b0;
   bit m_end = 1'b0;

   // scenario monitors
   int last_start, last_end, first_flush, n_key, n_flush, n_active;

   cypherdb_secure_seq #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ce            (ce),
      .enter_req     (enter_req),
      .exit_req      (exit_req),
      .exc_req       (exc_req),
      .key_req       (key_req),
      .key_ack       (key_ack),
      .flush_req     (flush_req),
      .flush_ack     (flush_ack),
      .start_pulse   (start_pulse),
      .end_pulse     (end_pulse),
      .secure_active (secure_active),
      .stall         (stall),
      .err           (err),
      .err_clr       (err_clr),
      .sec_cycles    (sec_cycles)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: applies the sequencing rules to the inputs seen at each edge.
   always @(posedge clk) begin
      bit go_in, go_out, err_ev;
      go_in   = ce && enter_req;
      go_out  = ce && exit_req;
      err_ev  = 1'b0;
      m_start = 1'b0;
      m_end   = 1'b0;
      if (rst) begin
         m_ph = M_IDLE; m_held = 0; m_sec = 0; m_pend = 1'b0; m_err = 1'b0;
      end else begin
         if (m_ph == M_IDLE) begin
            if (go_in) begin
               m_ph = M_KEY; m_held = 0; m_sec = 0; m_pend = 1'b0;
            end else if (go_out) begin
               err_ev = 1'b1;
            end
         end else if (m_ph == M_KEY) begin
            m_held++;
            if (exc_req || go_out) m_pend = 1'b1;
            if (key_ack) begin
               m_ph = M_ACTIVE; m_start = 1'b1;
            end else if (m_held == TIMEOUT) begin
               m_ph = M_IDLE; err_ev = 1'b1;
            end
         end else if (m_ph == M_ACTIVE) begin
            m_sec = (m_sec < SEC_MAX) ? m_sec + 1 : SEC_MAX;
            if (go_in) err_ev = 1'b1;
            if (go_out || exc_req || m_pend) begin
               m_ph = M_FLUSH; m_held = 0; m_pend = 1'b0;
            end
         end else begin
            m_held++;
            if (flush_ack) begin
               m_ph = M_IDLE; m_end = 1'b1;
            end else if (m_held == TIMEOUT) begin
               m_ph = M_IDLE; m_end = 1'b1; err_ev = 1'b1;
            end
         end
         if (err_ev) m_err = 1'b1;
         else if (err_clr) m_err = 1'b0;
      end
   end

   // Per-cycle comparison against the model plus scenario monitors.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("key_req", key_req, m_ph == M_KEY);
         chk("flush_req", flush_req, m_ph == M_FLUSH);
         chk("secure_active", secure_active, m_ph == M_ACTIVE);
         chk("stall", stall, (m_ph == M_KEY) || (m_ph == M_FLUSH));
         chk("start_pulse", start_pulse, m_start);
         chk("end_pulse", end_pulse, m_end);
         chk("err", err, m_err);
         chk("sec_cycles", sec_cycles, m_sec);
      end
      if (start_pulse === 1'b1) last_start = cyc;
      if (end_pulse === 1'b1) last_end = cyc;
      if (key_req === 1'b1) n_key++;
      if (flush_req === 1'b1) begin
         n_flush++;
         if (first_flush < 0) first_flush = cyc;
      end
      if (secure_active === 1'b1) n_active++;
   end

   task automatic clear_mon();
      last_start = -1; last_end = -1; first_flush = -1;
      n_key = 0; n_flush = 0; n_active = 0;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // v = {enter, exit, exc, key_ack, flush_ack, err_clr}, held for cycle c only
   task automatic at(input int c, input logic [5:0] v);
      wait_cyc(c);
      {enter_req, exit_req, exc_req, key_ack, flush_ack, err_clr} = v;
      wait_cyc(c + 1);
      {enter_req, exit_req, exc_req, key_ack, flush_ack, err_clr} = 6'b0;
   endtask

   localparam logic [5:0] V_ENTER = 6'b100000;
   localparam logic [5:0] V_EXIT  = 6'b010000;
   localparam logic [5:0] V_EXC   = 6'b001000;
   localparam logic [5:0] V_KACK  = 6'b000100;
   localparam logic [5:0] V_FACK  = 6'b000010;
   localparam logic [5:0] V_CLR   = 6'b000001;

   task automatic chk_all_zero(input string tag);
      chk({tag, "_outs"}, {key_req, flush_req, start_pulse, end_pulse,
                           secure_active, stall, err}, 32'd0);
      chk({tag, "_sec"}, sec_cycles, 32'd0);
   endtask

   initial begin
      int b;
      clear_mon();
      // reset
      wait_cyc(3);
      rst = 1'b0;
      cmp_en = 1'b1;
      chk_all_zero("reset");

      // basic sequence
      clear_mon(); b = cyc;
      at(b + 10, V_ENTER);
      chk("basic_key_n1", key_req, 1'b1);
      chk("basic_stall_n1", stall, 1'b1);
      at(b + 15, V_KACK);
      at(b + 30, V_EXIT);
      at(b + 33, V_FACK);
      wait_cyc(b + 36);
      chk("basic_start_cyc", last_start, b + 16);
      chk("basic_end_cyc", last_end, b + 34);
      chk("basic_sec", sec_cycles, 15);
      chk("basic_err", err, 1'b0);

      // exception during KEY
      clear_mon(); b = cyc;
      at(b + 10, V_ENTER);
      at(b + 12, V_EXC);
      at(b + 15, V_KACK);
      at(b + 20, V_FACK);
      wait_cyc(b + 23);
      chk("exc_start_cyc", last_start, b + 16);
      chk("exc_flush_cyc", first_flush, b + 17);
      chk("exc_active_n", n_active, 1);

      // key timeout
      clear_mon(); b = cyc;
      at(b + 2, V_ENTER);
      wait_cyc(b + 11);
      chk("kto_key_dropped", key_req, 1'b0);
      wait_cyc(b + 12);
      chk("kto_key_n", n_key, TIMEOUT);
      chk("kto_no_start", last_start, -1);
      chk("kto_err", err, 1'b1);
      at(b + 13, V_CLR);
      chk("kto_err_clr", err, 1'b0);

      // illegal events
      clear_mon(); b = cyc;
      at(b + 1, V_KACK);
      at(b + 2, V_EXIT);
      chk("ill_idle_exit_err", err, 1'b1);
      chk("ill_idle_exit_key", key_req, 1'b0);
      at(b + 4, V_CLR);
      wait_cyc(b + 6);
      ce = 1'b0; enter_req = 1'b1;
      wait_cyc(b + 7);
      ce = 1'b1; enter_req = 1'b0;
      wait_cyc(b + 8);
      chk("ill_ce0_key_n", n_key, 0);
      at(b + 8, V_ENTER);
      at(b + 10, V_KACK);
      at(b + 13, V_ENTER);
      chk("ill_nest_err", err, 1'b1);
      chk("ill_nest_active", secure_active, 1'b1);
      at(b + 15, V_EXIT);
      at(b + 17, V_FACK);
      wait_cyc(b + 19);
      chk("ill_sec", sec_cycles, 5);
      at(b + 19, V_CLR);

      // flush timeout
      clear_mon(); b = cyc;
      at(b + 2, V_ENTER);
      at(b + 4, V_KACK);
      at(b + 6, V_EXIT);
      wait_cyc(b + 17);
      chk("fto_flush_n", n_flush, TIMEOUT);
      chk("fto_end_cyc", last_end, b + 15);
      chk("fto_err", err, 1'b1);
      at(b + 18, V_CLR);

      // counter saturation
      clear_mon(); b = cyc;
      at(b + 2, V_ENTER);
      at(b + 4, V_KACK);
      wait_cyc(b + 12);
      chk("sat_mid", sec_cycles, 7);
      at(b + 24, V_EXIT);
      at(b + 27, V_FACK);
      wait_cyc(b + 30);
      chk("sat_active_n", n_active, 20);
      chk("sat_sec", sec_cycles, SEC_MAX);

      // reset during FLUSH
      clear_mon(); b = cyc;
      at(b + 2, V_ENTER);
      at(b + 4, V_KACK);
      at(b + 6, V_EXIT);
      wait_cyc(b + 8);
      chk("rstf_flush_pre", flush_req, 1'b1);
      rst = 1'b1;
      wait_cyc(b + 9);
      rst = 1'b0;
      chk_all_zero("rstf");
      wait_cyc(b + 13);
      chk("rstf_no_end", last_end, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
